mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive data grants over a waiting fetch before fetch is forced to win; legal range 1..15.
REQ-002 Parameter AW, default 32: address width.
REQ-003 clock  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 if_req  in  1  instruction-fetch request, held until granted.
REQ-006 if_addr  in  AW  fetch address, stable while if_req=1.
REQ-007 if_gnt  out  1  fetch request accepted this cycle.
REQ-008 if_rdata  out  32  fetched instruction, valid when if_valid=1.
REQ-009 if_valid  out  1  one-cycle fetch completion pulse.
REQ-010 dm_req  in  1  data-access request, held until granted.
REQ-011 dm_we  in  1  1 = store, 0 = load.
REQ-012 dm_addr  in  AW  data address.
REQ-013 dm_wdata  in  32  store data.
REQ-014 dm_gnt  out  1  data request accepted this cycle.
REQ-015 dm_rdata  out  32  load data, valid when dm_valid=1.
REQ-016 dm_valid  out  1  one-cycle load/store completion pulse.
REQ-017 mem_en  out  1  single-port memory access strobe.
REQ-018 mem_we  out  1  memory write enable, qualified by mem_en.
REQ-019 mem_addr  out  AW  memory address.
REQ-020 mem_wdata  out  32  memory write data.
REQ-021 mem_rdata  in  32  memory read data, valid when mem_ready=1.
REQ-022 mem_ready  in  1  memory completes the access this cycle; latency 1..N cycles.

Function
REQ-023 FSM states: IDLE, BUSY_IF, BUSY_DM; exactly one access in flight.
REQ-024 IDLE: if_gnt/dm_gnt are combinational, asserted in the same cycle as the winning request; the winner's addr/we/wdata are registered at that edge and the FSM moves to BUSY_IF or BUSY_DM.
REQ-025 Arbitration with one requester: it wins; with both requesting: dm wins unless starve_cnt == STARVE_LIMIT, in which case if wins.
REQ-026 starve_cnt increments (saturating at STARVE_LIMIT) on each dm grant while if_req=1, clears to 0 on every if grant, and holds otherwise.
REQ-027 No grant is issued outside IDLE; at most one gnt is high per cycle.
REQ-028 BUSY_x: mem_en=1; mem_addr/mem_we/mem_wdata driven from the registered values (mem_we=0 in BUSY_IF) and held constant until mem_ready=1.
REQ-029 On mem_ready=1 in BUSY_x: mem_rdata is captured into x_rdata, x_valid pulses high for exactly one cycle at the next edge, and the FSM returns to IDLE.
REQ-030 Minimum turnaround: grant at cycle t, mem_en during t+1.., valid at mem_ready cycle+1; a new grant is possible in the same cycle valid is high.
REQ-031 Store completion pulses dm_valid; dm_rdata is updated with mem_rdata (content don't-care to requester).
REQ-032 x_rdata holds its last captured value between completions.
REQ-033 mem_ready while in IDLE is ignored; requests that drop before grant are not remembered.
REQ-034 Outside BUSY states mem_en=0 and mem_we=0.

Reset
REQ-035 reset=0 forces, asynchronously: state IDLE, starve_cnt 0, mem_en 0, mem_we 0, if_valid 0, dm_valid 0, if_rdata 0, dm_rdata 0, registered addr/wdata 0.
REQ-036 Reset during BUSY aborts the access: no valid pulse is issued for it, and arbitration resumes in the first cycle after reset deasserts.

Verification
REQ-037 Lone fetch: if_req, if_addr=0x10, mem_ready 1 cycle after mem_en, mem_rdata=0x00500093 -> if_gnt at t, mem_en/mem_addr=0x10 at t+1, if_valid with if_rdata=0x00500093 at t+2.
REQ-038 Store with 3-cycle memory latency: dm_we=1, dm_addr=0x40, dm_wdata=0xDEADBEEF -> mem_en/mem_we held 3 cycles with constant address and data, then one dm_valid pulse, then return to IDLE.
REQ-039 Both requesting continuously, STARVE_LIMIT=4 -> grant order dm,dm,dm,dm,if,dm,dm,dm,dm,if...
REQ-040 Simultaneous requests with starve_cnt<limit -> dm_gnt=1, if_gnt=0; if_req is held and the fetch is granted in the IDLE cycle after dm completes.
REQ-041 reset pulsed low mid BUSY_DM -> mem_en drops immediately, no dm_valid is issued, starve_cnt=0, and a pending if_req is granted after release.
REQ-042 Checkers: never two gnts in a cycle; mem_en=0 implies mem_we=0; every gnt is matched by exactly one valid unless reset intervenes.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one single-port memory, one access in flight.
// Latency: grant is combinational in IDLE, mem_en the next cycle, valid one cycle after mem_ready.
// Backpressure: requesters hold req until gnt; the memory stalls the access by withholding mem_ready.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int AW           = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic [31:0]   if_rdata,
    output logic          if_valid,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [31:0]   dm_wdata,
    output logic          dm_gnt,
    output logic [31:0]   dm_rdata,
    output logic          dm_valid,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ready
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t        state_q, state_d;
    logic [3:0]    starve_q, starve_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [31:0]   dm_rdata_q, dm_rdata_d;
    logic          if_valid_q, if_valid_d;
    logic          dm_valid_q, dm_valid_d;
    logic          if_win, dm_win;

    // Data side wins ties until the fetch has been passed over STARVE_LIMIT times.
    always_comb begin
        if_win = if_req && (!dm_req || (starve_q == LIMIT));
        dm_win = dm_req && !if_win;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (if_win) begin
                    state_d = BUSY_IF;
                end else if (dm_win) begin
                    state_d = BUSY_DM;
                end
            end
            BUSY_IF, BUSY_DM: begin
                if (mem_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        if_gnt    = (state_q == IDLE) && if_win;
        dm_gnt    = (state_q == IDLE) && dm_win;
        mem_en    = (state_q == BUSY_IF) || (state_q == BUSY_DM);
        mem_we    = (state_q == BUSY_DM) && we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if_rdata  = if_rdata_q;
        if_valid  = if_valid_q;
        dm_rdata  = dm_rdata_q;
        dm_valid  = dm_valid_q;
    end

    always_comb begin
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        starve_d = starve_q;
        if (if_gnt) begin
            addr_d   = if_addr;
            we_d     = 1'b0;
            wdata_d  = '0;
            starve_d = '0;
        end else if (dm_gnt) begin
            addr_d  = dm_addr;
            we_d    = dm_we;
            wdata_d = dm_wdata;
            if (if_req && (starve_q < LIMIT)) begin
                starve_d = starve_q + 4'd1;
            end
        end
        // Stores also capture mem_rdata; the requester ignores it.
        if_valid_d = (state_q == BUSY_IF) && mem_ready;
        dm_valid_d = (state_q == BUSY_DM) && mem_ready;
        if_rdata_d = if_valid_d ? mem_rdata : if_rdata_q;
        dm_rdata_d = dm_valid_d ? mem_rdata : dm_rdata_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_q   <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
        end else begin
            starve_q   <= starve_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_valid_q <= if_valid_d;
            dm_valid_q <= dm_valid_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests, a latency-programmable memory responder,
// and a negedge monitor that checks grant order, memory accesses and completions against queues.
module tb_mem_arbiter;

    localparam byte G_IF = 8'h69;
    localparam byte G_DM = 8'h64;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          lat;
    } acc_t;

    logic        clock, reset;
    logic        if_req, if_gnt, if_valid;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_gnt, dm_valid;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        mem_en, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int tests = 0;
    int fails = 0;
    int viol  = 0;
    int lat   = 1;
    bit idle_ready = 0;

    byte  exp_gnt[$];
    acc_t exp_acc[$];
    logic [31:0] exp_if[$];
    logic [31:0] exp_dm[$];

    mem_arbiter #(.STARVE_LIMIT(4), .AW(32)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign mem_rdata = (mem_addr == 32'h10) ? 32'h0050_0093 : {mem_addr[15:0], 16'hC0DE};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory responder: mem_ready after `lat` cycles of mem_en.
    initial begin
        int cnt;
        cnt = 0;
        mem_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (!reset || !mem_en) begin
                cnt = 0;
                mem_ready = idle_ready;
            end else begin
                cnt++;
                mem_ready = (cnt >= lat);
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        bit gnt_prev, ready_prev, prev_dm, last_gnt_dm;
        int acc_cnt;
        byte g;
        gnt_prev = 0; ready_prev = 0; prev_dm = 0; last_gnt_dm = 0; acc_cnt = 0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                gnt_prev = 0; ready_prev = 0; acc_cnt = 0;
            end else begin
                if (if_gnt && dm_gnt) viol++;
                if (!mem_en && mem_we) viol++;
                if (gnt_prev) chk("gnt_to_mem_en", {31'd0, mem_en}, 32'd1);
                if (ready_prev || if_valid || dm_valid) begin
                    chk("if_valid_timing", {31'd0, if_valid}, {31'd0, ready_prev && !prev_dm});
                    chk("dm_valid_timing", {31'd0, dm_valid}, {31'd0, ready_prev && prev_dm});
                    if (if_req || dm_req)
                        chk("gnt_in_valid_cycle", {31'd0, if_gnt | dm_gnt}, 32'd1);
                end
                if (if_valid) begin
                    if (exp_if.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL if_valid_unexpected: got pulse expected none at %0t", $time);
                    end else chk("if_rdata", if_rdata, exp_if.pop_front());
                end
                if (dm_valid) begin
                    if (exp_dm.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL dm_valid_unexpected: got pulse expected none at %0t", $time);
                    end else chk("dm_rdata", dm_rdata, exp_dm.pop_front());
                end
                if (if_gnt || dm_gnt) begin
                    g = if_gnt ? G_IF : G_DM;
                    last_gnt_dm = dm_gnt;
                    if (exp_gnt.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL gnt_unexpected: got %c expected none at %0t", g, $time);
                    end else chk("gnt_order", {24'd0, g}, {24'd0, exp_gnt.pop_front()});
                end
                if (mem_en) begin
                    if (exp_acc.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL mem_en_unexpected: got 1 expected 0 at %0t", $time);
                    end else begin
                        acc_cnt++;
                        chk("mem_addr", mem_addr, exp_acc[0].addr);
                        chk("mem_we", {31'd0, mem_we}, {31'd0, exp_acc[0].we});
                        if (exp_acc[0].we) chk("mem_wdata", mem_wdata, exp_acc[0].wdata);
                        if (mem_ready) begin
                            chk("busy_cycles", acc_cnt, exp_acc[0].lat);
                            void'(exp_acc.pop_front());
                            acc_cnt = 0;
                        end
                    end
                end
                gnt_prev   = if_gnt || dm_gnt;
                ready_prev = mem_en && mem_ready;
                prev_dm    = last_gnt_dm;
            end
        end
    end

    task automatic wait_gnt(input bit is_if);
        int n;
        bit got;
        n = 0;
        got = 0;
        while (!got && n < 200) begin
            @(negedge clock);
            n++;
            got = is_if ? if_gnt : dm_gnt;
        end
        if (!got) begin
            tests++; fails++;
            $display("FAIL gnt_timeout: got no grant expected %s grant", is_if ? "if" : "dm");
        end
        @(posedge clock);
        #1;
    endtask

    task automatic req_if(input logic [31:0] a);
        if_addr = a;
        if_req  = 1'b1;
        wait_gnt(1'b1);
        if_req  = 1'b0;
    endtask

    task automatic req_dm(input logic we, input logic [31:0] a, input logic [31:0] d);
        dm_we    = we;
        dm_addr  = a;
        dm_wdata = d;
        dm_req   = 1'b1;
        wait_gnt(1'b0);
        dm_req   = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push_acc(input logic [31:0] a, input logic we, input logic [31:0] d, input int l);
        acc_t e;
        e.addr = a; e.we = we; e.wdata = d; e.lat = l;
        exp_acc.push_back(e);
    endtask

    task automatic pulse_reset();
        @(posedge clock);
        #3 reset = 1'b0;
        repeat (2) @(posedge clock);
        #3 reset = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        if_req = 0; if_addr = 0;
        dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
        #1 reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_dm_valid", {31'd0, dm_valid}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_dm_rdata", dm_rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        @(posedge clock);
        #3 reset = 1'b1;
        cycles(2);

        // Lone fetch, 1-cycle memory
        lat = 1;
        exp_gnt.push_back(G_IF);
        push_acc(32'h10, 1'b0, 32'h0, 1);
        exp_if.push_back(32'h0050_0093);
        req_if(32'h10);
        cycles(4);

        // Store, 3-cycle memory
        lat = 3;
        exp_gnt.push_back(G_DM);
        push_acc(32'h40, 1'b1, 32'hDEAD_BEEF, 3);
        exp_dm.push_back(32'h0040_C0DE);
        req_dm(1'b1, 32'h40, 32'hDEAD_BEEF);
        cycles(6);

        // Load, 2-cycle memory; rdata registers hold afterwards
        lat = 2;
        exp_gnt.push_back(G_DM);
        push_acc(32'h84, 1'b0, 32'h0, 2);
        exp_dm.push_back(32'h0084_C0DE);
        req_dm(1'b0, 32'h84, 32'h0);
        cycles(6);
        @(negedge clock);
        chk("if_rdata_hold", if_rdata, 32'h0050_0093);
        chk("dm_rdata_hold", dm_rdata, 32'h0084_C0DE);
        cycles(1);

        // Simultaneous requests: dm first, fetch in dm's completion cycle
        lat = 1;
        exp_gnt.push_back(G_DM); exp_gnt.push_back(G_IF);
        push_acc(32'h100, 1'b0, 32'h0, 1);
        push_acc(32'h200, 1'b0, 32'h0, 1);
        exp_dm.push_back(32'h0100_C0DE);
        exp_if.push_back(32'h0200_C0DE);
        fork
            req_dm(1'b0, 32'h100, 32'h0);
            req_if(32'h200);
        join
        cycles(4);

        // Continuous contention: d,d,d,d,i,d,d,d,d,i
        for (int k = 0; k < 10; k++) begin
            if (k == 4) begin
                exp_gnt.push_back(G_IF);
                push_acc(32'h500, 1'b0, 32'h0, 1);
                exp_if.push_back(32'h0500_C0DE);
            end else if (k == 9) begin
                exp_gnt.push_back(G_IF);
                push_acc(32'h504, 1'b0, 32'h0, 1);
                exp_if.push_back(32'h0504_C0DE);
            end else begin
                int j;
                j = (k < 4) ? k : k - 1;
                exp_gnt.push_back(G_DM);
                push_acc(32'h300 + 32'(4 * j), 1'b0, 32'h0, 1);
                exp_dm.push_back({16'h0300 + 16'(4 * j), 16'hC0DE});
            end
        end
        fork
            for (int k = 0; k < 8; k++) req_dm(1'b0, 32'h300 + 32'(4 * k), 32'h0);
            for (int k = 0; k < 2; k++) req_if(32'h500 + 32'(4 * k));
        join
        cycles(4);

        // mem_ready while idle is ignored
        idle_ready = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("idle_ready_if_valid", {31'd0, if_valid}, 32'd0);
            chk("idle_ready_dm_valid", {31'd0, dm_valid}, 32'd0);
        end
        idle_ready = 0;
        cycles(2);

        // Reset in the middle of a store; the waiting fetch is granted after release
        lat = 4;
        exp_gnt.push_back(G_DM); exp_gnt.push_back(G_DM); exp_gnt.push_back(G_DM);
        push_acc(32'h700, 1'b0, 32'h0, 4);
        push_acc(32'h704, 1'b0, 32'h0, 4);
        push_acc(32'h708, 1'b1, 32'h1234_5678, 4);
        exp_dm.push_back(32'h0700_C0DE);
        exp_dm.push_back(32'h0704_C0DE);
        if_addr = 32'h600;
        if_req  = 1'b1;
        req_dm(1'b0, 32'h700, 32'h0);
        req_dm(1'b0, 32'h704, 32'h0);
        req_dm(1'b1, 32'h708, 32'h1234_5678);
        #2 reset = 1'b0;
        if (exp_acc.size() > 0) void'(exp_acc.pop_front());
        #1;
        chk("rst_async_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_async_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_async_dm_rdata", dm_rdata, 32'd0);
        exp_gnt.push_back(G_IF);
        push_acc(32'h600, 1'b0, 32'h0, 4);
        exp_if.push_back(32'h0600_C0DE);
        repeat (2) @(posedge clock);
        #3 reset = 1'b1;
        wait_gnt(1'b1);
        if_req = 1'b0;
        cycles(8);

        // Reset clears the starvation count
        lat = 1;
        for (int k = 0; k < 3; k++) begin
            exp_gnt.push_back(G_DM);
            push_acc(32'h900 + 32'(4 * k), 1'b0, 32'h0, 1);
            exp_dm.push_back({16'h0900 + 16'(4 * k), 16'hC0DE});
        end
        if_addr = 32'h800;
        if_req  = 1'b1;
        for (int k = 0; k < 3; k++) req_dm(1'b0, 32'h900 + 32'(4 * k), 32'h0);
        if_req = 1'b0;
        cycles(3);
        pulse_reset();
        cycles(1);
        for (int k = 0; k < 4; k++) begin
            exp_gnt.push_back(G_DM);
            push_acc(32'hA00 + 32'(4 * k), 1'b0, 32'h0, 1);
            exp_dm.push_back({16'h0A00 + 16'(4 * k), 16'hC0DE});
        end
        exp_gnt.push_back(G_IF);
        push_acc(32'hB00, 1'b0, 32'h0, 1);
        exp_if.push_back(32'h0B00_C0DE);
        fork
            for (int k = 0; k < 4; k++) req_dm(1'b0, 32'hA00 + 32'(4 * k), 32'h0);
            req_if(32'hB00);
        join
        cycles(5);

        chk("exp_gnt_drained", exp_gnt.size(), 32'd0);
        chk("exp_acc_drained", exp_acc.size(), 32'd0);
        chk("exp_if_drained", exp_if.size(), 32'd0);
        chk("exp_dm_drained", exp_dm.size(), 32'd0);
        chk("protocol_violations", viol, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
